// File: rtl/alu_issue_if.sv
// Bundle of the command, ALU-drive and result signals around alu_issue_stage.
// master is the issue stage's own view; slave is the view of the surrounding logic.
interface alu_issue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Command side
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_acc;

  // ALU side
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;

  // Result side and status
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    input  in_valid, in_op, in_a, in_b, in_acc, alu_y, out_ready,
    output in_ready, alu_op, alu_a, alu_b, out_valid, out_y, out_op, acc, fifo_count
  );

  modport slave (
    output in_valid, in_op, in_a, in_b, in_acc, alu_y, out_ready,
    input  in_ready, alu_op, alu_a, alu_b, out_valid, out_y, out_op, acc, fifo_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Command FIFO feeding a combinational ALU, with a registered result and an
// accumulator that lets a command take the previous result as its A operand.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  alu_issue_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
  } cmd_t;

  // Command storage
  cmd_t             mem_q [DEPTH];
  cmd_t             wr_cmd;
  cmd_t             head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Result register and accumulator
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q,     out_y_d;
  logic [2:0]       out_op_q,    out_op_d;
  logic [WIDTH-1:0] acc_q,       acc_d;

  logic             fifo_empty;
  logic             in_ready;
  logic             push;
  logic             pop;

  // Handshake decode. in_ready deliberately ignores a same-cycle pop.
  always_comb begin
    fifo_empty = (count_q == '0);
    in_ready   = (count_q < CNT_W'(DEPTH));
    push       = bus.in_valid && in_ready;
    pop        = !fifo_empty && (!out_valid_q || bus.out_ready);
    head       = mem_q[rd_ptr_q];
    wr_cmd     = '{op: bus.in_op, a: bus.in_a, b: bus.in_b, use_acc: bus.in_acc};
  end

  // ALU operand drive; an empty FIFO presents all zeros.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bus.alu_op = 3'b000;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    if (!fifo_empty) begin
      bus.alu_op = head.op;
      bus.alu_b  = head.b;
      bus.alu_a  = head.use_acc ? acc_q : head.a;
    end
  end

  // Pointer and occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Result register: an issue overwrites, a bare consume only drops valid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_op_d    = out_op_q;
    acc_d       = acc_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_y_d     = bus.alu_y;
      out_op_d    = head.op;
      acc_d       = bus.alu_y;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_op_q    <= 3'b000;
      acc_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_op_q    <= out_op_d;
      acc_q       <= acc_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= wr_cmd;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_op     = out_op_q;
  assign bus.acc        = acc_q;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a reference ALU behind the alu_* path, a queue-based
// transaction model compared every cycle, plus directed literal expectations.
module tb_alu_issue_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  alu_issue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a + 1;
      3'b110:  return a - 1;
      default: return b;
    endcase
  endfunction

  // The ALU itself, outside the design under test.
  always_comb bus.alu_y = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transaction model: queue of pending commands, one result slot, accumulator.
  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
  } mcmd_t;

  mcmd_t            mq[$];
  mcmd_t            mh;
  bit               m_valid = 0;
  logic [WIDTH-1:0] m_y = 0;
  logic [2:0]       m_op = 0;
  logic [WIDTH-1:0] m_acc = 0;
  bit               m_push, m_pop;
  logic [WIDTH-1:0] m_res;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_valid = 0;
      m_y     = 0;
      m_op    = 0;
      m_acc   = 0;
    end else begin
      m_push = bus.in_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() != 0) && (!m_valid || bus.out_ready);
      if (m_pop) begin
        mh    = mq.pop_front();
        m_res = alu_f(mh.op, mh.use_acc ? m_acc : mh.a, mh.b);
        m_y   = m_res;
        m_op  = mh.op;
        m_acc = m_res;
        m_valid = 1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
      if (m_push) begin
        mq.push_back('{op: bus.in_op, a: bus.in_a, b: bus.in_b, use_acc: bus.in_acc});
      end
    end
  end

  // Compare process, mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("m_in_ready",   bus.in_ready,   64'(mq.size() < DEPTH));
      check("m_fifo_count", bus.fifo_count, 64'(mq.size()));
      check("m_out_valid",  bus.out_valid,  64'(m_valid));
      check("m_acc",        bus.acc,        64'(m_acc));
      if (mq.size() != 0) begin
        check("m_alu_op", bus.alu_op, 64'(mq[0].op));
        check("m_alu_a",  bus.alu_a,  64'(mq[0].use_acc ? m_acc : mq[0].a));
        check("m_alu_b",  bus.alu_b,  64'(mq[0].b));
      end else begin
        check("m_alu_idle", {bus.alu_op, bus.alu_a, bus.alu_b}, 64'd0);
      end
      if (m_valid) begin
        check("m_out_y",  bus.out_y,  64'(m_y));
        check("m_out_op", bus.out_op, 64'(m_op));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic use_acc);
    bus.in_valid = 1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_acc   = use_acc;
  endtask

  // Offer a command and hold it until accepted, with a cycle budget.
  task automatic push_hold(input string name, input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic use_acc);
    bit done = 0;
    drive(op, a, b, use_acc);
    for (int i = 0; i < 20 && !done; i++) begin
      done = bus.in_ready;
      step();
    end
    if (!done) check(name, 0, 1);
    bus.in_valid = 0;
  endtask

  initial begin
    int exp_y;
    bit drop;
    bus.in_valid  = 0;
    bus.in_op     = 0;
    bus.in_a      = 0;
    bus.in_b      = 0;
    bus.in_acc    = 0;
    bus.out_ready = 1;

    // 1. Reset for two cycles while a command is offered.
    reset = 1;
    drive(3'b001, 5, 7, 0);
    step();
    step();
    reset = 0;
    bus.in_valid = 0;
    started = 1;
    check("rst_count",     bus.fifo_count, 0);
    check("rst_out_valid", bus.out_valid,  0);
    check("rst_acc",       bus.acc,        0);
    check("rst_in_ready",  bus.in_ready,   1);
    check("rst_alu_op",    bus.alu_op,     0);

    // 2. Single add.
    drive(3'b001, 5, 7, 0);
    step();
    bus.in_valid = 0;
    check("single_count", bus.fifo_count, 1);
    step();
    check("single_valid", bus.out_valid, 1);
    check("single_y",     bus.out_y,     12);
    check("single_op",    bus.out_op,    3'b001);
    check("single_acc",   bus.acc,       12);
    step();
    check("single_release", bus.out_valid, 0);

    // 3. Chained increments on the accumulator.
    drive(3'b101, 0, 0, 1);
    step();
    step();
    check("chain_y1", bus.out_y, 13);
    step();
    check("chain_y2", bus.out_y, 14);
    bus.in_valid = 0;
    step();
    check("chain_y3", bus.out_y, 15);
    check("chain_acc", bus.acc, 15);
    step();

    // 4. Backpressure with pass-B commands 1..6.
    bus.out_ready = 0;
    for (int i = 1; i <= 5; i++) push_hold("bp_push_timeout", 3'b111, 0, i, 0);
    drive(3'b111, 0, 6, 0);
    for (int i = 0; i < 3; i++) step();
    check("bp_count",    bus.fifo_count, 4);
    check("bp_in_ready", bus.in_ready,   0);
    check("bp_held_y",   bus.out_y,      1);
    check("bp_valid",    bus.out_valid,  1);
    bus.out_ready = 1;
    exp_y = 1;
    for (int i = 0; i < 20 && exp_y < 7; i++) begin
      if (bus.out_valid) begin
        check("bp_order", bus.out_y, 64'(exp_y));
        exp_y++;
      end
      drop = bus.in_valid && bus.in_ready;
      step();
      if (drop) bus.in_valid = 0;
    end
    check("bp_drained", 64'(exp_y), 7);
    for (int i = 0; i < 3; i++) step();

    // 5. Wrap-around arithmetic, then simultaneous push/pop across a pointer wrap.
    drive(3'b010, 0, 1, 0);
    step();
    drive(3'b101, 0, 0, 1);
    step();
    bus.in_valid = 0;
    check("wrap_sub", bus.out_y, 32'hFFFF_FFFF);
    step();
    check("wrap_inc", bus.out_y, 32'h0000_0000);
    step();
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(3'b111, 0, 32'h10 + i, 0);
      step();
    end
    check("pp_count_start", bus.fifo_count, 2);
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 0, 32'h20 + i, 0);
      step();
      check("pp_count_hold", bus.fifo_count, 2);
    end
    bus.in_valid = 0;
    for (int i = 0; i < 5; i++) step();

    // 6. Reset with queued work and a stalled result.
    bus.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 0, 32'h30 + i, 0);
      step();
    end
    check("mid_count", bus.fifo_count, 3);
    check("mid_valid", bus.out_valid,  1);
    reset = 1;
    step();
    reset = 0;
    bus.in_valid = 0;
    check("mid_rst_count", bus.fifo_count, 0);
    check("mid_rst_valid", bus.out_valid,  0);
    check("mid_rst_acc",   bus.acc,        0);
    bus.out_ready = 1;
    drive(3'b100, 32'hF0, 32'h0F, 0);
    step();
    bus.in_valid = 0;
    step();
    check("fresh_y",     bus.out_y,     32'hFF);
    check("fresh_op",    bus.out_op,    3'b100);
    check("fresh_valid", bus.out_valid, 1);
    step();
    check("fresh_release", bus.out_valid, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
